memio_bridge: RTL and testbench

- Parametrised memory/IO bridge between the CPU datapath (ALU address, register write data) and data memory plus IO_CH memory-mapped peripheral channels.
- Adds the following over the single-cycle bridge:
  - byte/half/word lanes with byte enables and sign extension;
  - per-channel latched output registers;
  - a wait-state FSM that stalls the CPU for multi-cycle memory reads;
  - misalignment detection.

---
 rtl/memio_bridge.sv | 253 +++++++++++++++++++++++++
 tb/tb_memio_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memio_bridge.sv
// Memory/IO bridge: byte/half/word lanes, latched IO channel outputs, read wait-state FSM, misalignment/decode errors.
// Optional: define MEMIO_READBACK_EN so reads at channel offset +2 return the latched io_out value.
module memio_bridge #(
  parameter int          DATA_W    = 32,
  parameter int          IO_CH     = 4,
  parameter int          IO_W      = 16,
  parameter logic [31:0] IO_BASE   = 32'hFFFFFC60,
  parameter logic [31:0] CH_STRIDE = 32'h00000010,
  parameter int          MEM_LAT   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           caddress,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic                  ioread,
  input  logic                  iowrite,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W-1:0]     mread_data,
  input  logic [IO_CH*IO_W-1:0] io_in,
  output logic [31:0]           address,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     write_data,
  output logic [DATA_W-1:0]     rdata,
  output logic                  stall,
  output logic [IO_CH*IO_W-1:0] io_out,
  output logic [IO_CH-1:0]      io_cs,
  output logic                  addr_err
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam int         CNT_W   = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

  // Pick the addressed byte/half out of a word and fill the upper bits.
  function automatic logic [31:0] extract_load(input logic [31:0] src, input logic [1:0] off,
                                               input logic [1:0] sz, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = src[7:0];
      2'b01:   b = src[15:8];
      2'b10:   b = src[23:16];
      default: b = src[31:24];
    endcase
    h = off[1] ? src[31:16] : src[15:0];
    case (sz)
      2'b00:   extract_load = {{24{sx & b[7]}}, b};
      2'b01:   extract_load = {{16{sx & h[15]}}, h};
      default: extract_load = src;
    endcase
  endfunction

  logic [1:0]            state_r, state_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic [31:0]           hold_r, hold_nxt_s;
  logic [IO_CH*IO_W-1:0] io_out_r, io_out_nxt_s;
  logic                  addr_err_r;

  logic                  mem_req_s, io_req_s, any_req_s;
  logic                  misalign_s, multi_err_s, dec_err_s, err_s;
  logic                  mem_rd_ok_s, io_rd_ok_s, io_wr_ok_s, mem_we_s;
  logic [IO_CH-1:0]      hit_s;
  logic [3:0]            be_s;
  logic [31:0]           lane_data_s;
  logic [IO_W-1:0]       io_wmask_s;
  logic [IO_W-1:0]       io_sel_in_s;
  logic [15:0]           io_hi16_s;
  logic [31:0]           io_src_s, mem_ext_s, rdata_s;

  assign mem_req_s = memread | memwrite;
  assign io_req_s  = ioread | iowrite;
  assign any_req_s = mem_req_s | io_req_s;

  genvar g;
  for (g = 0; g < IO_CH; g++) begin : g_dec
    localparam logic [31:0] CH_ADDR = IO_BASE + CH_STRIDE * 32'(g);
    assign hit_s[g] = io_req_s && (caddress[31:2] == CH_ADDR[31:2]);
  end

  // Alignment check by access size; reserved size behaves as word.
  always_comb begin
    case (size)
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = caddress[0];
      default: misalign_s = (caddress[1:0] != 2'b00);
    endcase
  end

  assign multi_err_s = ((memread | ioread) & (memwrite | iowrite)) | (mem_req_s & io_req_s);
  assign dec_err_s   = io_req_s & ~(|hit_s);
  assign err_s       = any_req_s & (misalign_s | multi_err_s | dec_err_s);

  assign mem_rd_ok_s = memread & ~err_s;
  assign io_rd_ok_s  = ioread & ~err_s;
  assign io_wr_ok_s  = iowrite & ~err_s;
  assign mem_we_s    = memwrite & ~err_s & (state_r == ST_IDLE);

  // Store lane steering: replicate narrow data across lanes, enable only the addressed ones.
  always_comb begin
    case (size)
      2'b00: begin
        be_s        = 4'b0001 << caddress[1:0];
        lane_data_s = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_s        = caddress[1] ? 4'b1100 : 4'b0011;
        lane_data_s = {2{wdata[15:0]}};
      end
      default: begin
        be_s        = 4'b1111;
        lane_data_s = wdata;
      end
    endcase
  end

  // Channel byte mask: only lanes that overlap the IO_W-bit register matter.
  always_comb begin
    io_wmask_s = {IO_W{1'b0}};
    for (int b = 0; b < IO_W; b++) begin
      io_wmask_s[b] = be_s[b/8];
    end
  end

  // Next value of every channel output register.
  always_comb begin
    io_out_nxt_s = io_out_r;
    for (int k = 0; k < IO_CH; k++) begin
      if (io_wr_ok_s && hit_s[k]) begin
        io_out_nxt_s[k*IO_W +: IO_W] = (io_out_r[k*IO_W +: IO_W] & ~io_wmask_s)
                                     | (lane_data_s[IO_W-1:0] & io_wmask_s);
      end else begin
        io_out_nxt_s[k*IO_W +: IO_W] = io_out_r[k*IO_W +: IO_W];
      end
    end
  end

  // Mux the selected channel input; hit_s is one-hot so OR-ing is safe.
  always_comb begin
    io_sel_in_s = {IO_W{1'b0}};
    for (int k = 0; k < IO_CH; k++) begin
      io_sel_in_s = io_sel_in_s | ({IO_W{hit_s[k]}} & io_in[k*IO_W +: IO_W]);
    end
  end

`ifdef MEMIO_READBACK_EN
  logic [IO_W-1:0] io_sel_out_s;

  // Offset +2 reads back the latched output register of the selected channel.
  always_comb begin
    io_sel_out_s = {IO_W{1'b0}};
    for (int k = 0; k < IO_CH; k++) begin
      io_sel_out_s = io_sel_out_s | ({IO_W{hit_s[k]}} & io_out_r[k*IO_W +: IO_W]);
    end
  end
  assign io_hi16_s = 16'(io_sel_out_s);
`else
  assign io_hi16_s = 16'(io_sel_in_s);
`endif

  // The +2 register sits in the upper half so normal half/byte extraction finds it.
  assign io_src_s  = caddress[1] ? {io_hi16_s, 16'h0000} : 32'(io_sel_in_s);
  assign mem_ext_s = extract_load(mread_data, caddress[1:0], size, sign_ext);

  // Wait-state FSM; MEM_LAT stall cycles include the request cycle itself.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    hold_nxt_s  = hold_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_rd_ok_s && (MEM_LAT > 1)) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = CNT_W'(MEM_LAT - 1);
        end else if (mem_rd_ok_s && (MEM_LAT == 1)) begin
          state_nxt_s = ST_DONE;
          hold_nxt_s  = mem_ext_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!mem_rd_ok_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r <= CNT_W'(1)) begin
          state_nxt_s = ST_DONE;
          cnt_nxt_s   = {CNT_W{1'b0}};
          hold_nxt_s  = mem_ext_s;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter, holding register, channel outputs and error pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      hold_r     <= 32'h0000_0000;
      io_out_r   <= {(IO_CH*IO_W){1'b0}};
      addr_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      hold_r     <= hold_nxt_s;
      io_out_r   <= io_out_nxt_s;
      addr_err_r <= err_s;
    end
  end

  // Load result: IO reads and zero-latency memory resolve in the request cycle.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (io_rd_ok_s) begin
          rdata_s = extract_load(io_src_s, caddress[1:0], size, sign_ext);
        end else if (mem_rd_ok_s && (MEM_LAT == 0)) begin
          rdata_s = mem_ext_s;
        end else begin
          rdata_s = 32'h0000_0000;
        end
      end
      ST_DONE: rdata_s = hold_r;
      default: rdata_s = 32'h0000_0000;
    endcase
  end

  assign address    = mem_req_s ? {caddress[31:2], 2'b00} : 32'h0000_0000;
  assign mem_we     = mem_we_s;
  assign mem_be     = mem_we_s ? be_s : 4'b0000;
  assign write_data = mem_we_s ? lane_data_s : 32'h0000_0000;
  assign rdata      = rdata_s;
  // Reset forces stall low even while the CPU still holds its read request.
  assign stall      = ~reset & ((state_r == ST_WAIT)
                    | ((state_r == ST_IDLE) & mem_rd_ok_s & (MEM_LAT > 0)));
  assign io_out     = io_out_r;
  assign io_cs      = (io_req_s & ~err_s) ? hit_s : {IO_CH{1'b0}};
  assign addr_err   = addr_err_r;

endmodule

// File: tb/tb_memio_bridge.sv
// Scoreboard testbench for memio_bridge (MEM_LAT=2, four 16-bit channels).
module tb_memio_bridge;
  localparam int IO_CH = 4;
  localparam int IO_W  = 16;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [31:0]           caddress;
  logic                  memread, memwrite, ioread, iowrite;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [31:0]           wdata, mread_data;
  logic [IO_CH*IO_W-1:0] io_in;
  logic [31:0]           address;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [31:0]           write_data, rdata;
  logic                  stall;
  logic [IO_CH*IO_W-1:0] io_out;
  logic [IO_CH-1:0]      io_cs;
  logic                  addr_err;

  always #5 clock = ~clock;

  memio_bridge #(
    .DATA_W(32), .IO_CH(IO_CH), .IO_W(IO_W), .IO_BASE(32'hFFFFFC60),
    .CH_STRIDE(32'h00000010), .MEM_LAT(2)
  ) dut (
    .clock(clock), .reset(reset), .caddress(caddress), .memread(memread),
    .memwrite(memwrite), .ioread(ioread), .iowrite(iowrite), .size(size),
    .sign_ext(sign_ext), .wdata(wdata), .mread_data(mread_data), .io_in(io_in),
    .address(address), .mem_we(mem_we), .mem_be(mem_be), .write_data(write_data),
    .rdata(rdata), .stall(stall), .io_out(io_out), .io_cs(io_cs), .addr_err(addr_err)
  );

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] addr;
  } st_exp_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  st_exp_t     st_q[$];
  logic [15:0] model_out[IO_CH];

  function automatic logic [31:0] ch_addr(input int k);
    return 32'hFFFFFC60 + 32'h00000010 * 32'(k);
  endfunction

  function automatic logic [63:0] pack_model();
    logic [63:0] r;
    for (int k = 0; k < IO_CH; k++) r[k*16 +: 16] = model_out[k];
    return r;
  endfunction

  task automatic clear_req();
    memread = 1'b0; memwrite = 1'b0; ioread = 1'b0; iowrite = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_io_in(input int k, input logic [15:0] v);
    io_in[k*16 +: 16] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear_req();
    caddress = 32'h0; size = 2'b00; sign_ext = 1'b0; wdata = 32'h0; mread_data = 32'h0;
    io_in = 64'h0;
    for (int k = 0; k < IO_CH; k++) model_out[k] = 16'h0000;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (io_out !== 64'h0) begin errors++; $display("FAIL reset_io_out: got %h want 0", io_out); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
    checks++; if ({rdata, address, write_data} !== 96'h0) begin errors++; $display("FAIL reset_comb: rdata=%h address=%h write_data=%h want 0", rdata, address, write_data); end
    checks++; if ({mem_we, mem_be, io_cs} !== 9'h0) begin errors++; $display("FAIL reset_strobes: we=%b be=%b cs=%b want 0", mem_we, mem_be, io_cs); end
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_store();
    logic [31:0] a_t[5]  = '{32'h103, 32'h102, 32'h100, 32'h204, 32'h201};
    logic [1:0]  s_t[5]  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    logic [31:0] d_t[5]  = '{32'hA5, 32'h1234, 32'hCAFE, 32'hDEADBEEF, 32'h3C};
    logic [3:0]  be_t[5] = '{4'b1000, 4'b1100, 4'b0011, 4'b1111, 4'b0010};
    logic [31:0] wd_t[5] = '{32'hA5A5A5A5, 32'h12341234, 32'hCAFECAFE, 32'hDEADBEEF, 32'h3C3C3C3C};
    st_exp_t e;
    for (int i = 0; i < 5; i++) begin
      tick();
      memwrite = 1'b1; caddress = a_t[i]; size = s_t[i]; wdata = d_t[i];
      st_q.push_back('{be: be_t[i], data: wd_t[i], addr: a_t[i] & 32'hFFFFFFFC});
      #1;
      e = st_q.pop_front();
      checks++; if (mem_be !== e.be) begin errors++; $display("FAIL store_be[%0d]: got %b want %b", i, mem_be, e.be); end
      checks++; if (write_data !== e.data) begin errors++; $display("FAIL store_data[%0d]: got %h want %h", i, write_data, e.data); end
      checks++; if (address !== e.addr) begin errors++; $display("FAIL store_addr[%0d]: got %h want %h", i, address, e.addr); end
      checks++; if ({mem_we, stall} !== 2'b10) begin errors++; $display("FAIL store_we[%0d]: we=%b stall=%b want 1/0", i, mem_we, stall); end
    end
    tick(); clear_req(); #1;
    checks++; if ({mem_we, write_data} !== 33'h0) begin errors++; $display("FAIL store_idle: we=%b data=%h want 0", mem_we, write_data); end
  endtask

  task automatic test_stalled_load();
    logic [31:0] a_t[5] = '{32'h101, 32'h102, 32'h102, 32'h104, 32'h003};
    logic [1:0]  s_t[5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    logic        x_t[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] m_t[5] = '{32'h00008000, 32'h87654321, 32'h87654321, 32'h13579BDF, 32'h80000000};
    logic [31:0] r_t[5] = '{32'hFFFFFF80, 32'h00008765, 32'hFFFF8765, 32'h13579BDF, 32'h00000080};
    int n;
    for (int i = 0; i < 5; i++) begin
      tick();
      memread = 1'b1; caddress = a_t[i]; size = s_t[i]; sign_ext = x_t[i]; mread_data = m_t[i];
      exp_q.push_back(r_t[i]);
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_req_stall[%0d]: got %b want 1", i, stall); end
      n = 0;
      while (stall === 1'b1 && n < 20) begin
        tick(); n++;
        if (stall === 1'b1) begin
          checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL load_wait_rdata[%0d]: got %h want 0", i, rdata); end
        end
      end
      checks++; if (n !== 2) begin errors++; $display("FAIL load_stall_cycles[%0d]: got %0d want 2", i, n); end
      checks++; if (rdata !== exp_q[0]) begin errors++; $display("FAIL load_rdata[%0d]: got %h want %h", i, rdata, exp_q[0]); end
      void'(exp_q.pop_front());
      clear_req();
    end
    tick();
    checks++; if ({stall, rdata} !== 33'h0) begin errors++; $display("FAIL load_idle: stall=%b rdata=%h want 0", stall, rdata); end
  endtask

  task automatic test_io();
    tick();
    iowrite = 1'b1; size = 2'b10; caddress = ch_addr(1); wdata = 32'h1234BEEF;
    model_out[1] = 16'hBEEF;
    #1;
    checks++; if (io_cs !== 4'b0010) begin errors++; $display("FAIL io_wr_cs: got %b want 0010", io_cs); end
    checks++; if ({mem_we, stall} !== 2'b00) begin errors++; $display("FAIL io_wr_strobe: we=%b stall=%b want 0", mem_we, stall); end
    tick(); clear_req();
    checks++; if (io_out !== pack_model()) begin errors++; $display("FAIL io_wr_word: got %h want %h", io_out, pack_model()); end
    iowrite = 1'b1; size = 2'b00; caddress = ch_addr(3) + 32'd1; wdata = 32'h5A;
    model_out[3][15:8] = 8'h5A;
    tick(); clear_req();
    checks++; if (io_out !== pack_model()) begin errors++; $display("FAIL io_wr_byte: got %h want %h", io_out, pack_model()); end
    iowrite = 1'b1; size = 2'b01; caddress = ch_addr(2) + 32'd2; wdata = 32'h7777;
    tick(); clear_req();
    checks++; if (io_out !== pack_model()) begin errors++; $display("FAIL io_wr_upper: got %h want %h", io_out, pack_model()); end
    set_io_in(0, 16'h0080); set_io_in(1, 16'h00F0); set_io_in(3, 16'hA5C3);
    ioread = 1'b1; size = 2'b10; sign_ext = 1'b0; caddress = ch_addr(1);
    exp_q.push_back(32'h000000F0);
    #1;
    checks++; if (rdata !== exp_q[0]) begin errors++; $display("FAIL io_rd_word: got %h want %h", rdata, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if ({stall, io_cs} !== 5'b00010) begin errors++; $display("FAIL io_rd_cs: stall=%b cs=%b want 0/0010", stall, io_cs); end
    size = 2'b00; sign_ext = 1'b1; caddress = ch_addr(0);
    exp_q.push_back(32'hFFFFFF80);
    #1;
    checks++; if (rdata !== exp_q[0]) begin errors++; $display("FAIL io_rd_byte_sx: got %h want %h", rdata, exp_q[0]); end
    void'(exp_q.pop_front());
    size = 2'b01; sign_ext = 1'b0; caddress = ch_addr(3);
    exp_q.push_back(32'h0000A5C3);
    #1;
    checks++; if (rdata !== exp_q[0]) begin errors++; $display("FAIL io_rd_half_zx: got %h want %h", rdata, exp_q[0]); end
    void'(exp_q.pop_front());
    clear_req();
  endtask

  task automatic test_readback();
    int          k_t[2] = '{1, 3};
    logic        x_t[2] = '{1'b0, 1'b1};
    logic [15:0] hi;
    for (int i = 0; i < 2; i++) begin
      tick();
      ioread = 1'b1; size = 2'b01; sign_ext = x_t[i]; caddress = ch_addr(k_t[i]) + 32'd2;
`ifdef MEMIO_READBACK_EN
      hi = model_out[k_t[i]];
`else
      hi = io_in[k_t[i]*16 +: 16];
`endif
      exp_q.push_back(x_t[i] ? {{16{hi[15]}}, hi} : {16'h0000, hi});
      #1;
      checks++; if (rdata !== exp_q[0]) begin errors++; $display("FAIL readback[%0d]: got %h want %h", i, rdata, exp_q[0]); end
      void'(exp_q.pop_front());
      clear_req();
    end
  endtask

  task automatic test_misaligned();
    logic [3:0]  r_t[6] = '{4'b0100, 4'b1000, 4'b0010, 4'b1100, 4'b1010, 4'b0001};
    logic [1:0]  s_t[6] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [31:0] a_t[6];
    a_t = '{32'h102, 32'h101, ch_addr(0) + 32'd4, 32'h100, 32'h100, ch_addr(1) + 32'd2};
    for (int i = 0; i < 6; i++) begin
      tick();
      {memread, memwrite, ioread, iowrite} = r_t[i];
      size = s_t[i]; caddress = a_t[i]; wdata = 32'hFFFFFFFF; sign_ext = 1'b0;
      #1;
      checks++; if ({mem_we, mem_be, write_data, rdata} !== 69'h0) begin errors++; $display("FAIL err_suppress[%0d]: we=%b be=%b wd=%h rd=%h want 0", i, mem_we, mem_be, write_data, rdata); end
      checks++; if ({stall, io_cs, addr_err} !== 6'h0) begin errors++; $display("FAIL err_quiet[%0d]: stall=%b cs=%b err=%b want 0", i, stall, io_cs, addr_err); end
      tick(); clear_req();
      checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_pulse[%0d]: got %b want 1", i, addr_err); end
      tick();
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_pulse_end[%0d]: got %b want 0", i, addr_err); end
    end
    checks++; if (io_out !== pack_model()) begin errors++; $display("FAIL err_io_out: got %h want %h", io_out, pack_model()); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v_t[4] = '{16'h1357, 16'h2468, 16'h9ABC, 16'hFEDC};
    tick();
    iowrite = 1'b1; size = 2'b10; caddress = ch_addr(0); wdata = 32'h00001111;
    model_out[0] = 16'h1111;
    tick();
    size = 2'b01; caddress = ch_addr(2); wdata = 32'h0000ABCD;
    model_out[2] = 16'hABCD;
    tick(); clear_req();
    checks++; if (io_out !== pack_model()) begin errors++; $display("FAIL b2b_io_out: got %h want %h", io_out, pack_model()); end
    for (int k = 0; k < IO_CH; k++) set_io_in(k, v_t[k]);
    for (int k = 0; k < IO_CH; k++) begin
      ioread = 1'b1; size = 2'b10; sign_ext = 1'b0; caddress = ch_addr(k);
      exp_q.push_back({16'h0000, v_t[k]});
      #1;
      checks++; if (rdata !== exp_q[0]) begin errors++; $display("FAIL b2b_rd[%0d]: got %h want %h", k, rdata, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    clear_req();
  endtask

  task automatic test_abort();
    tick();
    memread = 1'b1; size = 2'b10; caddress = 32'h300; mread_data = 32'h11223344;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL abort_req_stall: got %b want 1", stall); end
    tick();
    memread = 1'b0;
    tick();
    checks++; if ({stall, rdata} !== 33'h0) begin errors++; $display("FAIL abort_idle: stall=%b rdata=%h want 0", stall, rdata); end
    tick();
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL abort_no_done: got %h want 0", rdata); end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    tick();
    memread = 1'b1; size = 2'b10; caddress = 32'h400; mread_data = 32'hCAFEF00D;
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstw_wait_stall: got %b want 1", stall); end
    #2 reset = 1'b1;
    for (int k = 0; k < IO_CH; k++) model_out[k] = 16'h0000;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstw_stall: got %b want 0", stall); end
    checks++; if ({io_out, addr_err} !== 65'h0) begin errors++; $display("FAIL rstw_regs: io_out=%h err=%b want 0", io_out, addr_err); end
    clear_req();
    tick();
    reset = 1'b0;
    memread = 1'b1; caddress = 32'h404; mread_data = 32'h0BADCAFE;
    exp_q.push_back(32'h0BADCAFE);
    #1;
    n = 0;
    while (stall === 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n !== 2) begin errors++; $display("FAIL rstw_relaunch_cycles: got %0d want 2", n); end
    checks++; if (rdata !== exp_q[0]) begin errors++; $display("FAIL rstw_relaunch_rdata: got %h want %h", rdata, exp_q[0]); end
    void'(exp_q.pop_front());
    clear_req();
    tick();
  endtask

  initial begin
    test_reset();
    test_store();
    test_stalled_load();
    test_io();
    test_readback();
    test_misaligned();
    test_back_to_back();
    test_abort();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
